booth_radix4_seq_mult: RTL and testbench
========================================

Name: booth_radix4_seq_mult

Overview:
- Sequential, parametrised radix-4 Booth multiplier for the multdiv unit.
- Successor to the single-step combinational Booth digit decoder. It adds:
  - an internal iteration state machine;
  - a start/ready handshake;
  - selectable signed or unsigned operands;
  - an overflow flag;
  - a generic operand width.
- Consumes one recoded multiplier digit per clock and produces a double-width product.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and >= 4.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin multiply; sampled only in IDLE
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
- multiplicand  input  WIDTH  operand A; captured with start
- multiplier  input  WIDTH  operand B; captured with start
- busy  output  1  high while an operation is in progress
- result_ready  output  1  one-cycle pulse when product is valid
- product  output  2*WIDTH  full product; held until the next accepted start
- overflow  output  1  product does not fit in WIDTH bits; valid with result_ready, then held

Behaviour:
- Reset (asynchronous): state IDLE; busy=0, result_ready=0, product=0, overflow=0; all internal registers cleared. A reset during RUN aborts the operation with no result.
- Internal operand width is W2=WIDTH+2. Both operands are extended by 2 bits:
  - sign extension when is_signed=1;
  - zero extension when is_signed=0.
- Iteration count is N=W2/2=WIDTH/2+1, the same for both modes.
- IDLE:
  - start=1 captures the operands and mode, clears the accumulator, sets the appended low bit q(-1)=0, and goes to RUN.
  - busy goes to 1 on the same edge.
- RUN, one digit per edge. The 3-bit window {q(2i+1), q(2i), q(2i-1)} selects the addend:
  - 000 or 111 -> 0
  - 001 or 010 -> +M
  - 011 -> +2M
  - 100 -> -2M
  - 101 or 110 -> -M
- Negative addends are formed as the bitwise inverse plus carry-in 1. The add is W2+1 bits wide.
- After each add, the accumulator/multiplier pair is shifted arithmetically right by 2.
- Iteration counter runs 0..N-1. On the last iteration the state goes to DONE.
- DONE (one cycle):
  - product = low 2*WIDTH bits of the accumulator/multiplier register;
  - result_ready=1, busy=0;
  - overflow computed;
  - next state IDLE.
- Latency: result_ready is high in the cycle after edge E0+N+1, where E0 is the start-sampling edge. For WIDTH=32 this is 18 edges.
- Throughput: one operation per N+2 cycles. A new start is accepted in the IDLE cycle after DONE.
- start while busy or in DONE: ignored. No queuing; the in-flight operands are not disturbed.
- start and result_ready together: impossible by construction, since start is sampled only in IDLE.
- Overflow rule:
  - signed: product[2*WIDTH-1:WIDTH-1] not all equal;
  - unsigned: product[2*WIDTH-1:WIDTH] != 0.
- Operand inputs need to be stable only at the start-sampling edge.

Optional Feature:
- Macro: BOOTH_EARLY_TERMINATE_EN.
- Defined: in RUN, if the remaining unconsumed multiplier bits, including the pending low bit, are all 0 or all 1, every remaining digit is zero.
  - The block then shifts the accumulator/multiplier register arithmetically right by 2×(remaining iterations) in one step and goes to DONE.
  - Latency becomes data-dependent: minimum 2 edges (start -> RUN with immediate detection -> DONE), maximum N+1 edges.
  - Products and overflow are identical to the non-terminating case.
- Undefined: fixed latency of N+1 edges. No detection logic is built.

Test Plan:
- Signed sign mix, WIDTH=32: is_signed=1, multiplicand=7, multiplier=32'hFFFFFFFD (-3) -> product=64'hFFFFFFFF_FFFFFFEB, overflow=0, result_ready exactly 18 edges after the start edge, busy high for 17 cycles.
- Unsigned max: is_signed=0, both operands 32'hFFFFFFFF -> product=64'hFFFFFFFE_00000001, overflow=1.
- Signed corner: is_signed=1, both operands 32'h80000000 -> product=64'h40000000_00000000, overflow=1. Also 32'h80000000 × 1 -> 64'hFFFFFFFF_80000000, overflow=0.
- Busy collision: start 12×10, then pulse start with 3×3 at iteration 4 -> that pulse is ignored; a single result_ready with product=120; a fresh start after DONE yields 9.
- Reset mid-operation: assert reset at iteration 5 -> busy, result_ready, product and overflow are all 0 immediately (asynchronous), and no result_ready follows. After release, 6×7 gives 42.
- Early termination (BOOTH_EARLY_TERMINATE_EN): signed 5×1 -> product=5, result_ready within 3 edges. 5×32'h40000000 -> product=64'h00000001_40000000, overflow=1, latency < 18 edges. With the macro undefined, both cases take 18 edges.

Source files
------------

// File: rtl/booth_radix4_seq_mult_if.sv
// Start/result handshake and operand/product bus of the sequential radix-4 Booth multiplier.
interface booth_radix4_seq_mult_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               result_ready;
  logic [2*WIDTH-1:0] product;
  logic               overflow;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  busy, result_ready, product, overflow
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output busy, result_ready, product, overflow
  );
endinterface

// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier, one recoded digit per clock, signed or unsigned operands.
// Optional macro BOOTH_EARLY_TERMINATE_EN finishes early once all remaining digits are zero.
module booth_radix4_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  booth_radix4_seq_mult_if.slave bus
);
  localparam int W2    = WIDTH + 2;
  localparam int N     = W2 / 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [W2-1:0]      mcand_r;
  logic [W2-1:0]      acc_r;
  logic [W2-1:0]      mq_r;
  logic               qm1_r;
  logic               signed_r;
  logic               busy_r;
  logic               ready_r;
  logic [2*WIDTH-1:0] product_r;
  logic               overflow_r;

  logic [2:0]         win_s;
  logic [W2:0]        addend_s;
  logic               neg_s;
  logic [W2:0]        sum_s;
  logic [W2-1:0]      acc_nxt_s;
  logic [W2-1:0]      mq_nxt_s;
  logic               qm1_nxt_s;
  logic [W2-1:0]      acc_fin_s;
  logic [W2-1:0]      mq_fin_s;
  logic               last_s;
  logic               finish_s;
  logic [2*W2-1:0]    pair_s;

  function automatic logic ovf_calc(input logic [2*WIDTH-1:0] p, input logic sgn);
    logic [WIDTH:0] hi;
    hi = p[2*WIDTH-1:WIDTH-1];
    if (sgn) begin
      return !((&hi) | ~(|hi));
    end else begin
      return |p[2*WIDTH-1:WIDTH];
    end
  endfunction

  assign win_s  = {mq_r[1:0], qm1_r};
  assign last_s = (cnt_r == CNT_W'(N - 1));
  assign pair_s = {acc_r, mq_r};

  // Booth digit decode: select 0, M or 2M and whether it is subtracted.
  always_comb begin
    addend_s = '0;
    neg_s    = 1'b0;
    case (win_s)
      3'b001, 3'b010: begin addend_s = {mcand_r[W2-1], mcand_r}; neg_s = 1'b0; end
      3'b011:         begin addend_s = {mcand_r, 1'b0};          neg_s = 1'b0; end
      3'b100:         begin addend_s = {mcand_r, 1'b0};          neg_s = 1'b1; end
      3'b101, 3'b110: begin addend_s = {mcand_r[W2-1], mcand_r}; neg_s = 1'b1; end
      default:        begin addend_s = '0;                       neg_s = 1'b0; end
    endcase
  end

  // One iteration: W2+1-bit add (subtract as invert plus carry-in) then arithmetic shift by 2.
  always_comb begin
    sum_s     = {acc_r[W2-1], acc_r} + (neg_s ? ~addend_s : addend_s) + {{W2{1'b0}}, neg_s};
    acc_nxt_s = {sum_s[W2], sum_s[W2:2]};
    mq_nxt_s  = {sum_s[1:0], mq_r[W2-1:2]};
    qm1_nxt_s = mq_r[1];
  end

`ifdef BOOTH_EARLY_TERMINATE_EN
  logic [31:0]     shamt_s;
  logic            all_zero_s;
  logic            all_ones_s;
  logic [2*W2-1:0] shifted_s;

  // Look ahead past this digit: uniform remaining bits mean only zero digits are left.
  always_comb begin
    shamt_s    = (32'(N - 1) - 32'(cnt_r)) << 1;
    all_zero_s = ~qm1_nxt_s;
    all_ones_s = qm1_nxt_s;
    for (int j = 0; j < W2; j++) begin
      if (32'(j) < shamt_s) begin
        all_zero_s = all_zero_s & ~mq_nxt_s[j];
        all_ones_s = all_ones_s & mq_nxt_s[j];
      end else begin
        all_zero_s = all_zero_s;
        all_ones_s = all_ones_s;
      end
    end
    shifted_s = $signed({acc_nxt_s, mq_nxt_s}) >>> shamt_s;
    acc_fin_s = shifted_s[2*W2-1:W2];
    mq_fin_s  = shifted_s[W2-1:0];
    finish_s  = last_s | all_zero_s | all_ones_s;
  end
`else
  // Fixed-latency build: always run every digit.
  always_comb begin
    acc_fin_s = acc_nxt_s;
    mq_fin_s  = mq_nxt_s;
    finish_s  = last_s;
  end
`endif

  // Iteration state machine and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      mcand_r    <= '0;
      acc_r      <= '0;
      mq_r       <= '0;
      qm1_r      <= 1'b0;
      signed_r   <= 1'b0;
      busy_r     <= 1'b0;
      ready_r    <= 1'b0;
      product_r  <= '0;
      overflow_r <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            mcand_r  <= {{2{bus.is_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
            mq_r     <= {{2{bus.is_signed & bus.multiplier[WIDTH-1]}}, bus.multiplier};
            acc_r    <= '0;
            qm1_r    <= 1'b0;
            cnt_r    <= '0;
            signed_r <= bus.is_signed;
            busy_r   <= 1'b1;
            state_r  <= ST_RUN;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_r <= acc_fin_s;
          mq_r  <= mq_fin_s;
          qm1_r <= qm1_nxt_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (finish_s) begin
            busy_r  <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          product_r  <= pair_s[2*WIDTH-1:0];
          overflow_r <= ovf_calc(pair_s[2*WIDTH-1:0], signed_r);
          ready_r    <= 1'b1;
          state_r    <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.result_ready = ready_r;
  assign bus.product      = product_r;
  assign bus.overflow     = overflow_r;
endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Directed vector bench for booth_radix4_seq_mult (WIDTH=32), table plus corner-case sequences.
module tb_booth_radix4_seq_mult;
  localparam int WIDTH = 32;
`ifdef BOOTH_EARLY_TERMINATE_EN
  localparam int COLL_DLY = 1;
`else
  localparam int COLL_DLY = 4;
`endif

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_p;
    logic        exp_ovf;
    int          max_lat;
  } vec_t;

  logic clock;
  logic reset;
  int   tests;
  int   fails;
  vec_t vecs[13];

  booth_radix4_seq_mult_if #(.WIDTH(WIDTH)) bus ();

  booth_radix4_seq_mult #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] p, output logic ov, output int lat, output int bcnt);
    @(negedge clock);
    bus.start        = 1'b1;
    bus.is_signed    = sgn;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clock);
    #1;
    bus.start        = 1'b0;
    bus.multiplicand = ~a;
    bus.multiplier   = ~b;
    bus.is_signed    = ~sgn;
    lat  = 0;
    bcnt = bus.busy ? 1 : 0;
    while (!bus.result_ready && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
      if (bus.busy) bcnt++;
    end
    p  = bus.product;
    ov = bus.overflow;
  endtask

  initial begin
    logic [63:0] p;
    logic        ov;
    int          lat;
    int          bcnt;
    int          rdy_cnt;
    logic [63:0] cap;

    tests = 0;
    fails = 0;
    vecs[0]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 18};
    vecs[1]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, 18};
    vecs[2]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1, 18};
    vecs[3]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 1'b0, 18};
    vecs[4]  = '{1'b1, 32'h0000_0005, 32'h0000_0001, 64'h0000_0000_0000_0005, 1'b0, 3};
    vecs[5]  = '{1'b1, 32'h0000_0005, 32'h4000_0000, 64'h0000_0001_4000_0000, 1'b1, 17};
    vecs[6]  = '{1'b0, 32'h0000_000C, 32'h0000_000A, 64'h0000_0000_0000_0078, 1'b0, 18};
    vecs[7]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 18};
    vecs[8]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1, 18};
    vecs[9]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000, 1'b0, 18};
    vecs[10] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 18};
    vecs[11] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1, 18};
    vecs[12] = '{1'b1, 32'hFFFF_0000, 32'h0001_0000, 64'hFFFF_FFFF_0000_0000, 1'b1, 18};

    bus.start        = 1'b0;
    bus.is_signed    = 1'b0;
    bus.multiplicand = 32'h0;
    bus.multiplier   = 32'h0;
    reset            = 1'b1;
    #12;
    chk("reset_busy",     {63'h0, bus.busy},         64'h0);
    chk("reset_ready",    {63'h0, bus.result_ready}, 64'h0);
    chk("reset_product",  bus.product,               64'h0);
    chk("reset_overflow", {63'h0, bus.overflow},     64'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, p, ov, lat, bcnt);
      chk($sformatf("vec%0d_product", i), p, vecs[i].exp_p);
      chk($sformatf("vec%0d_overflow", i), {63'h0, ov}, {63'h0, vecs[i].exp_ovf});
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(lat - 1));
`ifdef BOOTH_EARLY_TERMINATE_EN
      tests++;
      if (lat < 2 || lat > vecs[i].max_lat) begin
        fails++;
        $display("FAIL vec%0d_latency: got %0d edges, allowed 2..%0d", i, lat, vecs[i].max_lat);
      end
`else
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd18);
`endif
    end

    // Busy collision: a start during RUN must be ignored.
    @(negedge clock);
    bus.start = 1'b1; bus.is_signed = 1'b0;
    bus.multiplicand = 32'd12; bus.multiplier = 32'd10;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (COLL_DLY) @(posedge clock);
    @(negedge clock);
    chk("coll_busy_before_pulse", {63'h0, bus.busy}, 64'h1);
    bus.start = 1'b1; bus.multiplicand = 32'd3; bus.multiplier = 32'd3;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    rdy_cnt = 0;
    cap = 64'h0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock);
      #1;
      if (bus.result_ready) begin
        rdy_cnt++;
        cap = bus.product;
      end
    end
    chk("coll_ready_count", 64'(rdy_cnt), 64'd1);
    chk("coll_product", cap, 64'd120);
    chk("coll_product_held", bus.product, 64'd120);
    run_op(1'b0, 32'd3, 32'd3, p, ov, lat, bcnt);
    chk("coll_fresh_product", p, 64'd9);

    // Reset mid-operation aborts with no result.
    @(negedge clock);
    bus.start = 1'b1; bus.is_signed = 1'b1;
    bus.multiplicand = 32'h0001_2345; bus.multiplier = 32'h0000_6789;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("rst_busy_before", {63'h0, bus.busy}, 64'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_busy",     {63'h0, bus.busy},         64'h0);
    chk("rst_ready",    {63'h0, bus.result_ready}, 64'h0);
    chk("rst_product",  bus.product,               64'h0);
    chk("rst_overflow", {63'h0, bus.overflow},     64'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    rdy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock);
      #1;
      if (bus.result_ready) rdy_cnt++;
    end
    chk("rst_no_result", 64'(rdy_cnt), 64'd0);
    run_op(1'b1, 32'd6, 32'd7, p, ov, lat, bcnt);
    chk("rst_after_product", p, 64'd42);
    chk("rst_after_overflow", {63'h0, ov}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
